// File: rtl/bruh_stream_mem_writer.sv
// Byte-stream to 32-bit RAM writer: packs bytes little-endian and writes consecutive words from a base address.
// Latency: start -> in_ready one cycle; each word costs its byte-accept cycles plus one WRITE cycle; done one cycle after the last write.
// Backpressure: in_ready drops during WRITE/FINISH/IDLE; upstream bytes are held until in_valid & in_ready.
//
// Ports:
//   clk, reset                   clock and synchronous active-high reset
//   start, base_addr, byte_len   job request, sampled only while idle
//   busy, done, error            job status; done/error are one-cycle pulses
//   words_written                RAM writes issued by the current or last job
//   in_data, in_valid, in_ready  byte stream handshake
//   mem_*                        RAM slave write port (mem_clken tied high)
module bruh_stream_mem_writer #(
    parameter int ADDR_W = 13,
    parameter int LEN_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [LEN_W-1:0]  byte_len,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [ADDR_W:0]   words_written,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [3:0]        mem_byteenable,
    output logic              mem_chipselect,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    output logic              mem_clken
);

    // The end-of-job byte address needs enough bits to hold both a full
    // length and the scaled base without overflowing the comparison.
    localparam int CHK_W = ((LEN_W > ADDR_W + 2) ? LEN_W : ADDR_W + 2) + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PACK   = 2'd1,
        WRITE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    state_t           state;
    logic [LEN_W-1:0] remaining;
    logic [1:0]       lane;

    logic [CHK_W-1:0] req_end;
    logic [CHK_W-1:0] ram_bytes;
    logic             too_big;
    logic             accept;

    assign req_end   = CHK_W'({base_addr, 2'b00}) + CHK_W'(byte_len);
    assign ram_bytes = CHK_W'(1) << (ADDR_W + 2);
    assign too_big   = (req_end > ram_bytes);
    assign accept    = in_valid & in_ready;
    assign mem_clken = 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            remaining      <= '0;
            lane           <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            words_written  <= '0;
            in_ready       <= 1'b0;
            mem_address    <= '0;
            mem_byteenable <= '0;
            mem_chipselect <= 1'b0;
            mem_write      <= 1'b0;
            mem_writedata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done  <= 1'b0;
                    error <= 1'b0;
                    if (start) begin
                        mem_address    <= base_addr;
                        remaining      <= byte_len;
                        lane           <= '0;
                        words_written  <= '0;
                        mem_byteenable <= '0;
                        mem_writedata  <= '0;
                        busy           <= 1'b1;
                        if (byte_len == '0) begin
                            state <= FINISH;
                            done  <= 1'b1;
                        end else if (too_big) begin
                            state <= FINISH;
                            done  <= 1'b1;
                            error <= 1'b1;
                        end else begin
                            state    <= PACK;
                            in_ready <= 1'b1;
                        end
                    end
                end

                PACK: begin
                    if (accept) begin
                        mem_writedata[{lane, 3'b000} +: 8] <= in_data;
                        mem_byteenable[lane]               <= 1'b1;
                        remaining                          <= remaining - LEN_W'(1);
                        lane                               <= lane + 2'd1;
                        // Word is complete when the top lane fills or the
                        // stream runs out; the write is issued next cycle.
                        if (lane == 2'd3 || remaining == LEN_W'(1)) begin
                            state          <= WRITE;
                            in_ready       <= 1'b0;
                            mem_chipselect <= 1'b1;
                            mem_write      <= 1'b1;
                        end
                    end
                end

                WRITE: begin
                    mem_chipselect <= 1'b0;
                    mem_write      <= 1'b0;
                    mem_address    <= mem_address + ADDR_W'(1);
                    words_written  <= words_written + (ADDR_W + 1)'(1);
                    mem_byteenable <= '0;
                    mem_writedata  <= '0;
                    lane           <= '0;
                    if (remaining == '0) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end else begin
                        state    <= PACK;
                        in_ready <= 1'b1;
                    end
                end

                FINISH: begin
                    done  <= 1'b0;
                    error <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bruh_stream_mem_writer.sv
// Self-checking bench for bruh_stream_mem_writer: directed jobs, reference write list built per job.
// Latency: checks in_ready one cycle after start and done one cycle after the last write.
// Backpressure: exercises in_valid gaps and a start pulse while busy.
module tb_bruh_stream_mem_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [12:0] base_addr;
    logic [15:0] byte_len;
    logic        busy, done, error;
    logic [13:0] words_written;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [12:0] mem_address;
    logic [3:0]  mem_byteenable;
    logic        mem_chipselect, mem_write;
    logic [31:0] mem_writedata;
    logic        mem_clken;

    bruh_stream_mem_writer #(.ADDR_W(13), .LEN_W(16)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .byte_len(byte_len), .busy(busy), .done(done), .error(error),
        .words_written(words_written), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .mem_address(mem_address), .mem_byteenable(mem_byteenable),
        .mem_chipselect(mem_chipselect), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_clken(mem_clken)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [12:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } wr_t;

    wr_t expq[$];
    wr_t log_q[$];
    int  total = 0;
    int  bad = 0;
    int  done_cnt = 0;
    logic exp_err = 1'b0;
    int  exp_ww = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s", name);
    endtask

    // Reference: which words a job must write, from the byte stream alone.
    function automatic bit admitted(input int base, input int len);
        return (len != 0) && (base * 4 + len <= 4 * 8192);
    endfunction

    function automatic void model_job(input int base, input int len, input int first);
        wr_t w;
        expq.delete();
        exp_err = (len != 0) && !admitted(base, len);
        exp_ww  = 0;
        if (!admitted(base, len)) return;
        for (int i = 0; i < len; i += 4) begin
            w.a  = 13'(base + i / 4);
            w.d  = '0;
            w.be = '0;
            for (int j = 0; j < 4 && i + j < len; j++) begin
                w.d[8*j +: 8] = 8'(first + i + j);
                w.be[j]       = 1'b1;
            end
            expq.push_back(w);
            exp_ww++;
        end
    endfunction

    // Compare process: every RAM strobe and every done pulse against the reference.
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_write || mem_chipselect) begin
                log_q.push_back('{mem_address, mem_writedata, mem_byteenable});
                if (expq.size() == 0) begin
                    fail_now("unexpected_write");
                end else begin
                    wr_t e;
                    e = expq.pop_front();
                    chk("wr_cs", mem_chipselect, 1);
                    chk("wr_we", mem_write, 1);
                    chk("wr_addr", mem_address, e.a);
                    chk("wr_data", mem_writedata, e.d);
                    chk("wr_be", mem_byteenable, e.be);
                end
            end
            if (done) begin
                done_cnt++;
                chk("done_err", error, exp_err);
                chk("done_ww", words_written, exp_ww);
                chk("done_pending", expq.size(), 0);
            end else if (error) begin
                fail_now("error_without_done");
            end
        end
    end

    task automatic check_idle(input string tag);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_error"}, error, 0);
        chk({tag, "_ready"}, in_ready, 0);
        chk({tag, "_cs"}, mem_chipselect, 0);
        chk({tag, "_we"}, mem_write, 0);
        chk({tag, "_be"}, mem_byteenable, 0);
        chk({tag, "_wd"}, mem_writedata, 0);
        chk({tag, "_addr"}, mem_address, 0);
        chk({tag, "_ww"}, words_written, 0);
    endtask

    task automatic send_bytes(input int n, input int first, input bit toggle, input bit poke);
        int cyc;
        bit acc;
        cyc = 0;
        for (int i = 0; i < n; i++) begin
            int guard;
            guard = 0;
            in_data = 8'(first + i);
            forever begin
                in_valid = toggle ? cyc[0] : 1'b1;
                if (poke && i == 2) begin
                    start     = 1'b1;
                    base_addr = 13'h0100;
                    byte_len  = 16'd8;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                acc = in_valid && in_ready;
                @(posedge clk);
                #1;
                cyc++;
                guard++;
                if (acc) break;
                if (guard > 50) begin
                    fail_now("byte_accept_timeout");
                    break;
                end
            end
        end
        in_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic run_job(input int base, input int len, input int first,
                           input bit toggle, input bit poke);
        int d0;
        bit got;
        log_q.delete();
        model_job(base, len, first);
        d0 = done_cnt;
        base_addr = 13'(base);
        byte_len  = 16'(len);
        start     = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        if (admitted(base, len)) begin
            chk("ready_after_start", in_ready, 1);
            send_bytes(len, first, toggle, poke);
        end
        got = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (done_cnt > d0) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (!got) fail_now("done_timeout");
        chk("done_count", done_cnt - d0, 1);
        chk("busy_after_done", busy, 0);
        chk("writes_logged", log_q.size(), exp_ww);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; base_addr = '0; byte_len = '0;
        in_data = '0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_idle("rst");
        chk("clken", mem_clken, 1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Two full words.
        run_job(16'h0010, 8, 8'h01, 1'b0, 1'b0);
        if (log_q.size() >= 2) begin
            chk("t1_w0_data", log_q[0].d, 32'h04030201);
            chk("t1_w1_addr", log_q[1].a, 13'h0011);
            chk("t1_w1_data", log_q[1].d, 32'h08070605);
            chk("t1_w1_be", log_q[1].be, 4'hF);
        end
        chk("t1_ww", words_written, 2);

        // Partial final word.
        run_job(16'h0020, 6, 8'hA0, 1'b0, 1'b0);
        if (log_q.size() >= 2) begin
            chk("t2_w0_data", log_q[0].d, 32'hA3A2A1A0);
            chk("t2_w1_data", log_q[1].d, 32'h0000A5A4);
            chk("t2_w1_be", log_q[1].be, 4'h3);
        end

        // Empty job.
        run_job(16'h0030, 0, 0, 1'b0, 1'b0);
        chk("t3_nowrites", log_q.size(), 0);

        // Top of RAM: one byte past the end is rejected, exact fit is legal.
        run_job(16'h1FFF, 5, 8'h50, 1'b0, 1'b0);
        chk("t4_rejected_nowrites", log_q.size(), 0);
        run_job(16'h1FFF, 4, 8'h60, 1'b0, 1'b0);
        if (log_q.size() >= 1) begin
            chk("t4_last_addr", log_q[0].a, 13'h1FFF);
            chk("t4_last_data", log_q[0].d, 32'h63626160);
        end

        // Gapped valid plus a start pulse while busy.
        run_job(16'h0005, 4, 8'h00, 1'b1, 1'b1);
        if (log_q.size() >= 1) begin
            chk("t5_addr", log_q[0].a, 13'h0005);
            chk("t5_data", log_q[0].d, 32'h03020100);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("t5_start_ignored", busy, 0);

        // Reset mid-job after six bytes: second word must vanish, no done.
        begin
            int d0;
            log_q.delete();
            model_job(16'h0040, 8, 8'h10);
            d0 = done_cnt;
            base_addr = 13'h0040;
            byte_len  = 16'd8;
            start     = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            send_bytes(6, 8'h10, 1'b0, 1'b0);
            chk("t6_one_write", log_q.size(), 1);
            reset = 1'b1;
            @(posedge clk);
            #1;
            check_idle("t6_rst");
            expq.delete();
            reset = 1'b0;
            repeat (5) @(posedge clk);
            #1;
            chk("t6_no_done", done_cnt - d0, 0);
            chk("t6_no_more_writes", log_q.size(), 0 + 1);
        end

        // Normal job after the abort.
        run_job(16'h0100, 3, 8'hC0, 1'b0, 1'b0);
        if (log_q.size() >= 1) begin
            chk("t7_data", log_q[0].d, 32'h00C2C1C0);
            chk("t7_be", log_q[0].be, 4'h7);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
